// File: rtl/ahb2_pkg.sv
// ahb2_pkg: AHB2 HTRANS/HBURST/HRESP encodings and burst length helper.
package ahb2_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_WRAP8  = 3'b100;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_WRAP16 = 3'b110;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;
  localparam logic [1:0] HRESP_OKAY    = 2'b00;
  localparam logic [1:0] HRESP_ERROR   = 2'b01;
  localparam logic [1:0] HRESP_RETRY   = 2'b10;
  localparam logic [1:0] HRESP_SPLIT   = 2'b11;
  // Undefined-length bursts report 0: they never pin the grant.
  function automatic logic [4:0] burst_beats(logic [2:0] hburst);
    return (hburst == HBURST_WRAP4  || hburst == HBURST_INCR4)  ? 5'd4  :
           (hburst == HBURST_WRAP8  || hburst == HBURST_INCR8)  ? 5'd8  :
           (hburst == HBURST_WRAP16 || hburst == HBURST_INCR16) ? 5'd16 : 5'd0;
  endfunction
endpackage

// File: rtl/ahb2_rr_picker.sv
// ahb2_rr_picker: combinational rotate-priority one-hot picker, search starts after i_last.
module ahb2_rr_picker #(
  parameter int N = 4,
  localparam int LW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [LW-1:0] i_last,
  output logic [N-1:0]  o_gnt,
  output logic          o_valid
);
  always_comb begin
    o_gnt = '0;
    o_valid = 1'b0;
    for (int k = 1; k <= N; k++)
      if (!o_valid && i_req[(int'(i_last) + k) % N]) begin
        o_gnt[(int'(i_last) + k) % N] = 1'b1;
        o_valid = 1'b1;
      end
  end
endmodule

// File: rtl/ahb2_arbiter.sv
// ahb2_arbiter: round-robin AHB2 arbiter that never breaks fixed bursts or locked sequences,
// parking on DEFAULT_MASTER when idle.
module ahb2_arbiter
  import ahb2_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int DEFAULT_MASTER = 0,
  localparam int MW = $clog2(NUM_MASTERS)
) (
  input  logic                   hclk,
  input  logic                   hreset_n,
  input  logic [NUM_MASTERS-1:0] hbusreq_i,
  input  logic [NUM_MASTERS-1:0] hlock_i,
  input  logic [1:0]             htrans_i,
  input  logic [2:0]             hburst_i,
  input  logic                   hready_i,
  input  logic [1:0]             hresp_i,
  output logic [NUM_MASTERS-1:0] hgrant_o,
  output logic [MW-1:0]          hmaster_o,
  output logic                   hmastlock_o
);
  localparam logic [NUM_MASTERS-1:0] DEF_GNT = NUM_MASTERS'(1) << DEFAULT_MASTER;
  logic [4:0]             r_cnt;
  logic [4:0]             w_beats;
  logic [4:0]             w_cnt_d;
  logic [MW-1:0]          w_gidx;
  logic [NUM_MASTERS-1:0] w_pick;
  logic                   w_valid;
  logic                   w_rearb;
  always_comb begin
    w_gidx = '0;
    for (int i = 0; i < NUM_MASTERS; i++)
      if (hgrant_o[i]) w_gidx = MW'(i);
  end
  assign w_beats = burst_beats(hburst_i);
  // Non-OKAY responses (incl. RETRY/SPLIT) terminate the burst so the bus may move.
  assign w_cnt_d = (hresp_i != HRESP_OKAY)     ? 5'd0 :
                   (htrans_i == HTRANS_NONSEQ) ? ((w_beats == 5'd0) ? 5'd0 : w_beats - 5'd1) :
                   (htrans_i == HTRANS_SEQ)    ? ((r_cnt == 5'd0) ? 5'd0 : r_cnt - 5'd1) :
                   (htrans_i == HTRANS_BUSY)   ? r_cnt : 5'd0;
  assign w_rearb = (w_cnt_d <= 5'd1) && !hlock_i[w_gidx];
  ahb2_rr_picker #(.N(NUM_MASTERS)) u_picker (
    .i_req   (hbusreq_i),
    .i_last  (w_gidx),
    .o_gnt   (w_pick),
    .o_valid (w_valid)
  );
  always_ff @(posedge hclk) begin
    if (!hreset_n) begin
      hgrant_o    <= DEF_GNT;
      hmaster_o   <= MW'(DEFAULT_MASTER);
      hmastlock_o <= 1'b0;
      r_cnt       <= 5'd0;
    end else if (hready_i) begin
      hmaster_o   <= w_gidx;
      hmastlock_o <= hlock_i[w_gidx];
      r_cnt       <= w_cnt_d;
      if (w_rearb) hgrant_o <= w_valid ? w_pick : DEF_GNT;
    end
  end
endmodule

// File: tb/tb_ahb2_arbiter.sv
// tb_ahb2_arbiter: scenario-driven scoreboard bench for ahb2_arbiter (4 masters, default 0).
module tb_ahb2_arbiter;
  import ahb2_pkg::*;
  typedef struct packed {
    logic       rn;
    logic [3:0] req;
    logic [3:0] lock;
    logic [1:0] tr;
    logic [2:0] hb;
    logic       rdy;
    logic [1:0] rs;
    logic [3:0] g;
    logic [1:0] m;
    logic       l;
  } row_t;
  typedef struct packed {
    logic [3:0] g;
    logic [1:0] m;
    logic       l;
  } exp_t;
  logic       hclk = 1'b0;
  logic       hreset_n;
  logic [3:0] hbusreq_i;
  logic [3:0] hlock_i;
  logic [1:0] htrans_i;
  logic [2:0] hburst_i;
  logic       hready_i;
  logic [1:0] hresp_i;
  logic [3:0] hgrant_o;
  logic [1:0] hmaster_o;
  logic       hmastlock_o;
  exp_t sb[$];
  int total = 0;
  int passed = 0;
  ahb2_arbiter #(.NUM_MASTERS(4), .DEFAULT_MASTER(0)) dut (
    .hclk        (hclk),
    .hreset_n    (hreset_n),
    .hbusreq_i   (hbusreq_i),
    .hlock_i     (hlock_i),
    .htrans_i    (htrans_i),
    .hburst_i    (hburst_i),
    .hready_i    (hready_i),
    .hresp_i     (hresp_i),
    .hgrant_o    (hgrant_o),
    .hmaster_o   (hmaster_o),
    .hmastlock_o (hmastlock_o)
  );
  always #5 hclk = ~hclk;
  task automatic drive(input row_t r);
    hreset_n  = r.rn;
    hbusreq_i = r.req;
    hlock_i   = r.lock;
    htrans_i  = r.tr;
    hburst_i  = r.hb;
    hready_i  = r.rdy;
    hresp_i   = r.rs;
    sb.push_back('{r.g, r.m, r.l});
  endtask
  task automatic tick;
    @(posedge hclk);
    #1;
  endtask
  task automatic test_reset;
    row_t r;
    exp_t e;
    r = '{1'b0, 4'b0, 4'b0, HTRANS_IDLE, HBURST_SINGLE, 1'b1, HRESP_OKAY, 4'b0001, 2'd0, 1'b0};
    for (int i = 0; i < 11; i++) begin
      r.rn = (i != 0);
      drive(r);
      tick;
      e = sb.pop_front();
      total++;
      if ({hgrant_o, hmaster_o, hmastlock_o} !== {e.g, e.m, e.l})
        $display("FAIL reset[%0d]: got g=%b m=%0d l=%b want g=%b m=%0d l=%b", i, hgrant_o, hmaster_o, hmastlock_o, e.g, e.m, e.l);
      else passed++;
    end
  endtask
  task automatic test_round_robin;
    row_t r;
    exp_t e;
    logic [3:0] gs [4] = '{4'b0010, 4'b0100, 4'b0010, 4'b0100};
    logic [1:0] ms [4] = '{2'd0, 2'd1, 2'd2, 2'd1};
    for (int i = 0; i < 4; i++) begin
      r = '{1'b1, 4'b0110, 4'b0, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, HRESP_OKAY, gs[i], ms[i], 1'b0};
      drive(r);
      tick;
      e = sb.pop_front();
      total++;
      if ({hgrant_o, hmaster_o, hmastlock_o} !== {e.g, e.m, e.l})
        $display("FAIL round_robin[%0d]: got g=%b m=%0d l=%b want g=%b m=%0d l=%b", i, hgrant_o, hmaster_o, hmastlock_o, e.g, e.m, e.l);
      else passed++;
    end
  endtask
  task automatic test_burst_handover;
    exp_t e;
    row_t rows [13] = '{
      '{1'b1, 4'b0010, 4'b0, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, HRESP_OKAY, 4'b0010, 2'd2, 1'b0},
      '{1'b1, 4'b0010, 4'b0, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, HRESP_OKAY, 4'b0010, 2'd1, 1'b0},
      '{1'b1, 4'b1010, 4'b0, HTRANS_NONSEQ, HBURST_INCR4,  1'b1, HRESP_OKAY, 4'b0010, 2'd1, 1'b0},
      '{1'b1, 4'b1010, 4'b0, HTRANS_SEQ,    HBURST_INCR4,  1'b1, HRESP_OKAY, 4'b0010, 2'd1, 1'b0},
      '{1'b1, 4'b1010, 4'b0, HTRANS_SEQ,    HBURST_INCR4,  1'b1, HRESP_OKAY, 4'b1000, 2'd1, 1'b0},
      '{1'b1, 4'b1000, 4'b0, HTRANS_SEQ,    HBURST_INCR4,  1'b1, HRESP_OKAY, 4'b1000, 2'd3, 1'b0},
      '{1'b1, 4'b0010, 4'b0, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, HRESP_OKAY, 4'b0010, 2'd3, 1'b0},
      '{1'b1, 4'b0010, 4'b0, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, HRESP_OKAY, 4'b0010, 2'd1, 1'b0},
      '{1'b1, 4'b1010, 4'b0, HTRANS_NONSEQ, HBURST_INCR4,  1'b1, HRESP_OKAY, 4'b0010, 2'd1, 1'b0},
      '{1'b1, 4'b1010, 4'b0, HTRANS_SEQ,    HBURST_INCR4,  1'b1, HRESP_OKAY, 4'b0010, 2'd1, 1'b0},
      '{1'b1, 4'b1010, 4'b0, HTRANS_BUSY,   HBURST_INCR4,  1'b1, HRESP_OKAY, 4'b0010, 2'd1, 1'b0},
      '{1'b1, 4'b1010, 4'b0, HTRANS_SEQ,    HBURST_INCR4,  1'b1, HRESP_OKAY, 4'b1000, 2'd1, 1'b0},
      '{1'b1, 4'b1000, 4'b0, HTRANS_SEQ,    HBURST_INCR4,  1'b1, HRESP_OKAY, 4'b1000, 2'd3, 1'b0}
    };
    for (int i = 0; i < 13; i++) begin
      drive(rows[i]);
      tick;
      e = sb.pop_front();
      total++;
      if ({hgrant_o, hmaster_o, hmastlock_o} !== {e.g, e.m, e.l})
        $display("FAIL burst_handover[%0d]: got g=%b m=%0d l=%b want g=%b m=%0d l=%b", i, hgrant_o, hmaster_o, hmastlock_o, e.g, e.m, e.l);
      else passed++;
    end
  endtask
  task automatic test_lock;
    exp_t e;
    row_t rows [8] = '{
      '{1'b1, 4'b0100, 4'b0100, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, HRESP_OKAY, 4'b0100, 2'd3, 1'b0},
      '{1'b1, 4'b0111, 4'b0100, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, HRESP_OKAY, 4'b0100, 2'd2, 1'b1},
      '{1'b1, 4'b0111, 4'b0100, HTRANS_NONSEQ, HBURST_INCR,   1'b1, HRESP_OKAY, 4'b0100, 2'd2, 1'b1},
      '{1'b1, 4'b0111, 4'b0100, HTRANS_SEQ,    HBURST_INCR,   1'b1, HRESP_OKAY, 4'b0100, 2'd2, 1'b1},
      '{1'b1, 4'b0111, 4'b0100, HTRANS_NONSEQ, HBURST_INCR,   1'b1, HRESP_OKAY, 4'b0100, 2'd2, 1'b1},
      '{1'b1, 4'b0011, 4'b0100, HTRANS_SEQ,    HBURST_INCR,   1'b1, HRESP_OKAY, 4'b0100, 2'd2, 1'b1},
      '{1'b1, 4'b0011, 4'b0000, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, HRESP_OKAY, 4'b0001, 2'd2, 1'b0},
      '{1'b1, 4'b0011, 4'b0000, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, HRESP_OKAY, 4'b0010, 2'd0, 1'b0}
    };
    for (int i = 0; i < 8; i++) begin
      drive(rows[i]);
      tick;
      e = sb.pop_front();
      total++;
      if ({hgrant_o, hmaster_o, hmastlock_o} !== {e.g, e.m, e.l})
        $display("FAIL lock[%0d]: got g=%b m=%0d l=%b want g=%b m=%0d l=%b", i, hgrant_o, hmaster_o, hmastlock_o, e.g, e.m, e.l);
      else passed++;
    end
  endtask
  task automatic test_stall_error;
    exp_t e;
    row_t rows [10] = '{
      '{1'b1, 4'b0010, 4'b0000, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, HRESP_OKAY,  4'b0010, 2'd1, 1'b0},
      '{1'b1, 4'b0011, 4'b0000, HTRANS_NONSEQ, HBURST_INCR8,  1'b1, HRESP_OKAY,  4'b0010, 2'd1, 1'b0},
      '{1'b1, 4'b0011, 4'b0000, HTRANS_SEQ,    HBURST_INCR8,  1'b1, HRESP_OKAY,  4'b0010, 2'd1, 1'b0},
      '{1'b1, 4'b0011, 4'b0000, HTRANS_SEQ,    HBURST_INCR8,  1'b1, HRESP_OKAY,  4'b0010, 2'd1, 1'b0},
      '{1'b1, 4'b0011, 4'b0000, HTRANS_SEQ,    HBURST_INCR8,  1'b1, HRESP_OKAY,  4'b0010, 2'd1, 1'b0},
      '{1'b1, 4'b0011, 4'b0010, HTRANS_IDLE,   HBURST_INCR8,  1'b0, HRESP_ERROR, 4'b0010, 2'd1, 1'b0},
      '{1'b1, 4'b0011, 4'b0010, HTRANS_IDLE,   HBURST_INCR8,  1'b0, HRESP_ERROR, 4'b0010, 2'd1, 1'b0},
      '{1'b1, 4'b0011, 4'b0010, HTRANS_IDLE,   HBURST_INCR8,  1'b0, HRESP_ERROR, 4'b0010, 2'd1, 1'b0},
      '{1'b1, 4'b0011, 4'b0000, HTRANS_SEQ,    HBURST_INCR8,  1'b1, HRESP_ERROR, 4'b0001, 2'd1, 1'b0},
      '{1'b1, 4'b0000, 4'b0000, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, HRESP_OKAY,  4'b0001, 2'd0, 1'b0}
    };
    for (int i = 0; i < 10; i++) begin
      drive(rows[i]);
      tick;
      e = sb.pop_front();
      total++;
      if ({hgrant_o, hmaster_o, hmastlock_o} !== {e.g, e.m, e.l})
        $display("FAIL stall_error[%0d]: got g=%b m=%0d l=%b want g=%b m=%0d l=%b", i, hgrant_o, hmaster_o, hmastlock_o, e.g, e.m, e.l);
      else passed++;
    end
  endtask
  task automatic test_reset_mid_burst;
    exp_t e;
    row_t rows [8] = '{
      '{1'b1, 4'b1111, 4'b0000, HTRANS_NONSEQ, HBURST_WRAP16, 1'b1, HRESP_OKAY, 4'b0001, 2'd0, 1'b0},
      '{1'b1, 4'b1111, 4'b0000, HTRANS_SEQ,    HBURST_WRAP16, 1'b1, HRESP_OKAY, 4'b0001, 2'd0, 1'b0},
      '{1'b1, 4'b1111, 4'b0000, HTRANS_SEQ,    HBURST_WRAP16, 1'b1, HRESP_OKAY, 4'b0001, 2'd0, 1'b0},
      '{1'b0, 4'b1111, 4'b1111, HTRANS_SEQ,    HBURST_WRAP16, 1'b1, HRESP_OKAY, 4'b0001, 2'd0, 1'b0},
      '{1'b1, 4'b1111, 4'b0000, HTRANS_SEQ,    HBURST_WRAP16, 1'b1, HRESP_OKAY, 4'b0010, 2'd0, 1'b0},
      '{1'b1, 4'b1111, 4'b0000, HTRANS_SEQ,    HBURST_WRAP16, 1'b1, HRESP_OKAY, 4'b0100, 2'd1, 1'b0},
      '{1'b1, 4'b1111, 4'b0000, HTRANS_SEQ,    HBURST_WRAP16, 1'b1, HRESP_OKAY, 4'b1000, 2'd2, 1'b0},
      '{1'b1, 4'b1111, 4'b0000, HTRANS_SEQ,    HBURST_WRAP16, 1'b1, HRESP_OKAY, 4'b0001, 2'd3, 1'b0}
    };
    for (int i = 0; i < 8; i++) begin
      drive(rows[i]);
      tick;
      e = sb.pop_front();
      total++;
      if ({hgrant_o, hmaster_o, hmastlock_o} !== {e.g, e.m, e.l})
        $display("FAIL reset_mid_burst[%0d]: got g=%b m=%0d l=%b want g=%b m=%0d l=%b", i, hgrant_o, hmaster_o, hmastlock_o, e.g, e.m, e.l);
      else passed++;
    end
  endtask
  initial begin
    hreset_n  = 1'b0;
    hbusreq_i = '0;
    hlock_i   = '0;
    htrans_i  = HTRANS_IDLE;
    hburst_i  = HBURST_SINGLE;
    hready_i  = 1'b1;
    hresp_i   = HRESP_OKAY;
    tick;
    tick;
    test_reset;
    test_round_robin;
    test_burst_handover;
    test_lock;
    test_stall_error;
    test_reset_mid_burst;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
